// File: rtl/aes_buf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_buf_pkg : word width, block geometry and drain state type shared by the
//               AES word buffer and buffer_drain.            Revision 1.0
// ---------------------------------------------------------------------------
package aes_buf_pkg;

  localparam int WORD_W     = 32;
  localparam int BUF_WORDS  = 128;
  localparam int BUF_ADDR_W = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } drain_state_t;

endpackage
`default_nettype wire

// File: rtl/buffer_drain_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// buffer_drain_if : load/stream bundle of buffer_drain; checksum only when
//                   DRAIN_CHECKSUM_EN is defined.             Revision 1.0
// ---------------------------------------------------------------------------
interface buffer_drain_if
  import aes_buf_pkg::*;
#(
  parameter int WORDS  = BUF_WORDS,
  parameter int ADDR_W = BUF_ADDR_W
) ();

  logic                      load;
  logic [WORDS*WORD_W-1:0]   in_data;
  logic [ADDR_W:0]           count;
  logic                      ready;
  logic [ADDR_W-1:0]         address;
  logic [WORD_W-1:0]         data;
  logic                      en_write;
  logic                      busy;
  logic                      done;
`ifdef DRAIN_CHECKSUM_EN
  logic [WORD_W-1:0]         checksum;

  modport slave  (input  load, in_data, count, ready,
                  output address, data, en_write, busy, done, checksum);
  modport master (output load, in_data, count, ready,
                  input  address, data, en_write, busy, done, checksum);
`else
  modport slave  (input  load, in_data, count, ready,
                  output address, data, en_write, busy, done);
  modport master (output load, in_data, count, ready,
                  input  address, data, en_write, busy, done);
`endif

endinterface
`default_nettype wire

// File: rtl/drain_word_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// drain_word_sel : registered WORDS:1 word mux; a load preloads word 0 straight
//                  from the incoming block.                   Revision 1.0
// ---------------------------------------------------------------------------
module drain_word_sel
  import aes_buf_pkg::*;
#(
  parameter int WORDS  = BUF_WORDS,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORDS*WORD_W-1:0] i_words,
  input  logic [ADDR_W-1:0]       i_sel,
  input  logic                    i_sel_en,
  input  logic                    i_load_en,
  input  logic [WORD_W-1:0]       i_load_word,
  output logic [WORD_W-1:0]       o_word
);

  logic [WORD_W-1:0] w_words [WORDS];
  logic [WORD_W-1:0] r_word;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_unpack
    assign w_words[gi] = i_words[gi*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word <= '0;
    end else if (i_load_en) begin
      r_word <= i_load_word;
    end else if (i_sel_en) begin
      r_word <= w_words[i_sel];
    end
  end

  assign o_word = r_word;

endmodule
`default_nettype wire

// File: rtl/buffer_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// buffer_drain : captures a WORDS x 32 block, streams it as address/data/write
//                with sink backpressure; option DRAIN_CHECKSUM_EN. Revision 1.0
// ---------------------------------------------------------------------------
module buffer_drain
  import aes_buf_pkg::*;
#(
  parameter int WORDS  = BUF_WORDS,
  parameter int ADDR_W = BUF_ADDR_W
) (
  input  logic           clk,
  input  logic           reset,
  buffer_drain_if.slave  bus
);

  localparam logic [ADDR_W:0]   C_COUNT_MAX = (ADDR_W+1)'(WORDS);
  localparam logic [ADDR_W:0]   C_CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] C_IDX_ONE   = ADDR_W'(1);

  drain_state_t            r_state, w_state_nxt;
  logic [WORDS*WORD_W-1:0] r_mem;
  logic [ADDR_W:0]         r_count;
  logic [ADDR_W-1:0]       r_index;
  logic                    r_en_write, r_busy, r_done;
  logic                    w_en_write_nxt, w_busy_nxt, w_done_nxt;
  logic                    w_load_ok, w_handshake, w_last, w_advance;
  logic [ADDR_W:0]         w_count_clamp;
  logic [ADDR_W-1:0]       w_index_nxt;
  logic [WORD_W-1:0]       w_data;

  assign w_load_ok     = (r_state == IDLE) && bus.load;
  assign w_handshake   = r_en_write && bus.ready;
  assign w_last        = ({1'b0, r_index} == (r_count - C_CNT_ONE));
  assign w_advance     = w_handshake && !w_last;
  assign w_count_clamp = (bus.count > C_COUNT_MAX) ? C_COUNT_MAX : bus.count;
  assign w_index_nxt   = r_index + C_IDX_ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_en_write <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_en_write <= w_en_write_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.load) w_state_nxt = (w_count_clamp != '0) ? STREAM : DONE;
      STREAM:  if (w_handshake && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it.
  always_comb begin
    w_en_write_nxt = (w_state_nxt == STREAM);
    w_busy_nxt     = (w_state_nxt != IDLE);
    w_done_nxt     = (w_state_nxt == DONE);
  end

  // The index stops at count-1 so it can never wrap past the block.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem   <= '0;
      r_count <= '0;
      r_index <= '0;
    end else if (w_load_ok) begin
      r_mem   <= bus.in_data;
      r_count <= w_count_clamp;
      r_index <= '0;
    end else if (w_advance) begin
      r_index <= w_index_nxt;
    end
  end

  drain_word_sel #(
    .WORDS  (WORDS),
    .ADDR_W (ADDR_W)
  ) u_word_sel (
    .clk         (clk),
    .reset       (reset),
    .i_words     (r_mem),
    .i_sel       (w_index_nxt),
    .i_sel_en    (w_advance),
    .i_load_en   (w_load_ok),
    .i_load_word (bus.in_data[WORD_W-1:0]),
    .o_word      (w_data)
  );

`ifdef DRAIN_CHECKSUM_EN
  logic [WORD_W-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!reset || w_load_ok) begin
      r_checksum <= '0;
    end else if (w_handshake) begin
      r_checksum <= r_checksum ^ w_data;
    end
  end

  assign bus.checksum = r_checksum;
`endif

  assign bus.address  = r_index;
  assign bus.data     = w_data;
  assign bus.en_write = r_en_write;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_buffer_drain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_buffer_drain : directed blocks for buffer_drain; a negedge monitor checks
//                   every accepted word against a queue.     Revision 1.0
// ---------------------------------------------------------------------------
module tb_buffer_drain;
  import aes_buf_pkg::*;

  typedef struct packed {
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  buffer_drain_if bus ();

  buffer_drain dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t          q[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_hs     = 0;
  logic [6:0]    last_addr = '0;
  logic [4095:0] blk_a, blk_b, blk_c, blk_p;
  logic [6:0]    pat = 7'b1011001;  // ready per stream cycle, bit 0 first

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake seen by the sink must match the next queued word.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.en_write === 1'b1 && bus.ready === 1'b1) begin
      n_hs++;
      last_addr = bus.address;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_word: got address %0d with nothing expected", bus.address);
      end else begin
        mon_e = q.pop_front();
        chk("word_addr", 32'(bus.address), 32'(mon_e.addr));
        chk("word_data", bus.data, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4095:0] blk, input int cnt);
    int n;
    n = (cnt > 128) ? 128 : cnt;
    for (int i = 0; i < n; i++) q.push_back(exp_t'{addr: 7'(i), data: blk[32*i +: 32]});
    bus.in_data = blk;
    bus.count   = 8'(cnt);
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    chk("done_no_write", 32'(bus.en_write), 32'd0);
  endtask

  task automatic finish_block(input string tag);
    tick();
    chk({tag, "_done_cleared"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
  endtask

  task automatic wait_addr(input logic [6:0] a);
    for (int k = 0; k < 40 && bus.address != a; k++) tick();
    chk("reach_addr", 32'(bus.address), 32'(a));
  endtask

  initial begin
    int cyc;
    int hs0;
    logic [6:0]  pa;
    logic [31:0] pd;

    bus.load = 1'b0;
    bus.ready = 1'b0;
    bus.count = '0;
    bus.in_data = '0;
    blk_p = '0;
    for (int i = 0; i < 128; i++) begin
      blk_a[32*i +: 32] = 32'hA500_0000 + 32'(i);
      blk_b[32*i +: 32] = 32'hB7B7_0000 + 32'(i);
      blk_c[32*i +: 32] = 32'hC300_0000 + 32'(i);
    end
    blk_p[31:0] = 32'h1; blk_p[63:32] = 32'h2; blk_p[95:64] = 32'h4; blk_p[127:96] = 32'h8;

    // Reset state
    tick(); tick();
    chk("rst_address", 32'(bus.address), 32'd0);
    chk("rst_data", bus.data, 32'd0);
    chk("rst_en_write", 32'(bus.en_write), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    tick();

    // Full block, ready held high
    bus.ready = 1'b1;
    hs0 = n_hs;
    start(blk_a, 128);
    chk("full_first_addr", 32'(bus.address), 32'd0);
    chk("full_first_data", bus.data, 32'hA500_0000);
    chk("full_first_en", 32'(bus.en_write), 32'd1);
    chk("full_busy", 32'(bus.busy), 32'd1);
    wait_done(200, cyc);
    chk("full_cycles", 32'(cyc), 32'd128);
    chk("full_handshakes", 32'(n_hs - hs0), 32'd128);
    chk("full_last_addr", 32'(last_addr), 32'd127);
    finish_block("full");

    // Backpressure
    hs0 = n_hs;
    bus.ready = 1'b0;
    start(blk_a, 4);
    for (int i = 0; i < 7; i++) begin
      if (i > 0 && pat[i-1] == 1'b0) begin
        chk("stall_addr", 32'(bus.address), 32'(pa));
        chk("stall_data", bus.data, pd);
      end
      pa = bus.address;
      pd = bus.data;
      bus.ready = pat[i];
      tick();
    end
    chk("bp_done", 32'(bus.done), 32'd1);
    chk("bp_handshakes", 32'(n_hs - hs0), 32'd4);
    finish_block("bp");

    // count = 0
    bus.ready = 1'b1;
    hs0 = n_hs;
    start(blk_a, 0);
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_en_write", 32'(bus.en_write), 32'd0);
    chk("zero_busy", 32'(bus.busy), 32'd1);
    finish_block("zero");
    chk("zero_handshakes", 32'(n_hs - hs0), 32'd0);

    // count = 200 clamps to a full block
    hs0 = n_hs;
    start(blk_c, 200);
    wait_done(300, cyc);
    chk("clamp_cycles", 32'(cyc), 32'd128);
    chk("clamp_handshakes", 32'(n_hs - hs0), 32'd128);
    chk("clamp_last_addr", 32'(last_addr), 32'd127);
    finish_block("clamp");

    // Second load while streaming is ignored
    hs0 = n_hs;
    start(blk_a, 8);
    wait_addr(7'd2);
    bus.in_data = blk_b;
    bus.count   = 8'd3;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
    chk("reload_busy", 32'(bus.busy), 32'd1);
    wait_done(50, cyc);
    chk("reload_cycles", 32'(cyc), 32'd5);
    chk("reload_handshakes", 32'(n_hs - hs0), 32'd8);
    finish_block("reload");

    // Reset mid-stream discards the block
    hs0 = n_hs;
    start(blk_a, 10);
    wait_addr(7'd5);
    reset = 1'b0;
    tick();
    chk("mrst_address", 32'(bus.address), 32'd0);
    chk("mrst_data", bus.data, 32'd0);
    chk("mrst_en_write", 32'(bus.en_write), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_handshakes", 32'(n_hs - hs0), 32'd5);
    q.delete();
    reset = 1'b1;
    tick();
    chk("mrst_idle", 32'(bus.en_write), 32'd0);
    start(blk_c, 3);
    chk("restart_addr", 32'(bus.address), 32'd0);
    chk("restart_data", bus.data, 32'hC300_0000);
    chk("restart_en", 32'(bus.en_write), 32'd1);
    wait_done(20, cyc);
    chk("restart_cycles", 32'(cyc), 32'd3);
    finish_block("restart");

    // One-hot words: XOR of the streamed prefix
    start(blk_p, 4);
    wait_done(20, cyc);
`ifdef DRAIN_CHECKSUM_EN
    chk("checksum4", bus.checksum, 32'hF);
`endif
    finish_block("cks4");
    start(blk_p, 2);
    wait_done(20, cyc);
    chk("cks2_cycles", 32'(cyc), 32'd2);
`ifdef DRAIN_CHECKSUM_EN
    chk("checksum2", bus.checksum, 32'h3);
`endif
    finish_block("cks2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
